// File: rtl/gpio_pkg.sv
// Shared GPIO constants used by the debouncer, register block and interrupt controller.
package gpio_pkg;

    localparam int unsigned NUM_GPIO    = 32;
    localparam int unsigned DB_CFG_W    = 16;
    localparam int unsigned SYNC_STAGES = 2;

endpackage : gpio_pkg

// File: rtl/gpio_debounce_32_if.sv
// Pad-side and register-side signal bundle of the GPIO debouncer.
interface gpio_debounce_32_if #(
    parameter int unsigned NUM_GPIO = gpio_pkg::NUM_GPIO
);

    logic [NUM_GPIO-1:0]          gpio_pad_in;
    logic [gpio_pkg::DB_CFG_W-1:0] debounce_cfg;
    logic [NUM_GPIO-1:0]          gpio_in_db;
    logic [NUM_GPIO-1:0]          db_rise;
    logic [NUM_GPIO-1:0]          db_fall;

    modport master (
        output gpio_pad_in,
        output debounce_cfg,
        input  gpio_in_db,
        input  db_rise,
        input  db_fall
    );

    modport slave (
        input  gpio_pad_in,
        input  debounce_cfg,
        output gpio_in_db,
        output db_rise,
        output db_fall
    );

endinterface : gpio_debounce_32_if

// File: rtl/gpio_debounce_bit.sv
// Single-pin debouncer: pad synchronizer, stability counter, debounced level and edge pulses.
module gpio_debounce_bit
    import gpio_pkg::*;
(
    input  logic                PCLK,
    input  logic                PRESETn,
    input  logic                pad,
    input  logic [DB_CFG_W-1:0] cfg,
    output logic                level,
    output logic                rise,
    output logic                fall
);

    logic [SYNC_STAGES-1:0] sync_ff;
    logic                   sync_q;
    logic [DB_CFG_W-1:0]    cnt;
    logic [DB_CFG_W-1:0]    cnt_nxt;
    logic [DB_CFG_W-1:0]    limit;
    logic                   differ;
    logic                   update;

    assign sync_q = sync_ff[SYNC_STAGES-1];

    // N=0 is treated as N=1 so the threshold never underflows.
    always_comb begin
        limit   = '0;
        differ  = 1'b0;
        update  = 1'b0;
        cnt_nxt = '0;
        if (cfg != '0) begin
            limit = cfg - DB_CFG_W'(1);
        end
        differ = (sync_q != level);
        update = differ && (cnt >= limit);
        if (differ && !update) begin
            cnt_nxt = cnt + DB_CFG_W'(1);
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            sync_ff <= '0;
            cnt     <= '0;
            level   <= 1'b0;
            rise    <= 1'b0;
            fall    <= 1'b0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], pad};
            cnt     <= cnt_nxt;
            rise    <= update &&  sync_q;
            fall    <= update && !sync_q;
            if (update) begin
                level <= sync_q;
            end
        end
    end

endmodule : gpio_debounce_bit

// File: rtl/gpio_debounce_32.sv
// GPIO input debouncer: one independent per-pin filter for each of NUM_GPIO pads.
module gpio_debounce_32 #(
    parameter int unsigned NUM_GPIO = gpio_pkg::NUM_GPIO
) (
    input  logic               PCLK,
    input  logic               PRESETn,
    gpio_debounce_32_if.slave  bus
);

    logic [NUM_GPIO-1:0] level;
    logic [NUM_GPIO-1:0] rise;
    logic [NUM_GPIO-1:0] fall;

    for (genvar i = 0; i < NUM_GPIO; i++) begin : g_pin
        gpio_debounce_bit u_bit (
            .PCLK    (PCLK),
            .PRESETn (PRESETn),
            .pad     (bus.gpio_pad_in[i]),
            .cfg     (bus.debounce_cfg),
            .level   (level[i]),
            .rise    (rise[i]),
            .fall    (fall[i])
        );
    end

    assign bus.gpio_in_db = level;
    assign bus.db_rise    = rise;
    assign bus.db_fall    = fall;

endmodule : gpio_debounce_32

// File: doc/gpio_debounce_32.md
GPIO_DEBOUNCE_32 -- requirements
Module: gpio_debounce_32

Interface
REQ-001 The block SHALL use one clock and an asynchronous, active-low reset, and SHALL have these ports:
  PCLK          in   1   sole clock; all state changes on rising edge
  PRESETn       in   1   reset, asynchronous, active-low
  gpio_pad_in   in   32  raw, asynchronous pad input levels
  debounce_cfg  in   16  stable-cycle threshold N, from the register block
  gpio_in_db    out  32  debounced level per pin; feeds the register block's GPIO_IN read value and the interrupt controller
  db_rise       out  32  one-cycle pulse per pin on a debounced 0->1 change
  db_fall       out  32  one-cycle pulse per pin on a debounced 1->0 change
REQ-002 The block SHALL have one parameter: NUM_GPIO, default 32, number of pins.
REQ-003 All outputs SHALL be driven directly from flops, with no combinational path from any input.

Function
REQ-004 Each pin SHALL pass through a 2-flop synchronizer; sync_q is the second-stage output.
REQ-005 Each pin SHALL hold a 16-bit counter cnt[i] and a stable flop stable[i]; gpio_in_db[i] = stable[i].
REQ-006 Per cycle: sync_q==stable → cnt<=0.
REQ-007 Per cycle: sync_q!=stable and cnt>=Neff-1 → stable<=sync_q and cnt<=0, where Neff=max(N,1).
REQ-008 Per cycle: otherwise → cnt<=cnt+1.
REQ-009 The threshold comparison SHALL use >= against the current debounce_cfg; lowering N mid-count SHALL complete the update on the next edge, not stall.
REQ-010 N=0 and N=1 SHALL behave identically (no filtering): stable follows sync_q with 1 cycle of delay.
REQ-011 A pad step held steady SHALL appear on gpio_in_db exactly Neff+2 rising edges after the first edge that samples it.
REQ-012 A glitch shorter than Neff sampled cycles (after synchronization) SHALL NOT change gpio_in_db; cnt SHALL return to 0 when sync_q re-matches stable.
REQ-013 cnt SHALL never exceed 0xFFFF. For N=0xFFFF, the update SHALL occur at cnt=0xFFFE with no wrap.
REQ-014 db_rise[i] SHALL be 1 for exactly the one cycle in which stable[i] first reads 1 after a 0→1 update.
REQ-015 db_fall[i] SHALL follow the same rule for 1→0 updates.
REQ-016 db_rise[i] and db_fall[i] SHALL never both be 1 in the same cycle.
REQ-017 Pins SHALL be fully independent; simultaneous changes on any subset SHALL each debounce and pulse on their own.
REQ-018 A debounce_cfg change SHALL take effect on the next cycle for all pins. A change SHALL NOT reset cnt.

Reset
REQ-019 While PRESETn=0, sync flops, cnt, stable, gpio_in_db, db_rise and db_fall SHALL all be 0, asynchronously.
REQ-020 Reset deassertion SHALL be taken synchronously to PCLK by the surrounding reset logic; the block adds no synchronizer.
REQ-021 A pad held at 1 through reset SHALL produce one db_rise pulse Neff+2 edges after the first post-reset edge. This is intended behaviour.
REQ-022 Reset asserted mid-count SHALL discard the count; no pulse SHALL be emitted for that count.

Structure
REQ-023 Package gpio_pkg SHALL hold NUM_GPIO (32), DB_CFG_W (16) and SYNC_STAGES (2), shared with the register block and the interrupt controller.
REQ-024 Per-pin logic SHALL live in sub-module gpio_debounce_bit (synchronizer, counter, stable flop, edge pulses), instantiated NUM_GPIO times by generate.
REQ-025 The top level SHALL contain only the generate loop and port bundling.

Verification
REQ-026 Scenario 1: N=4; pin 0 steps 0→1 and holds. Required: gpio_in_db[0]=1 exactly 6 edges later; db_rise[0] high one cycle; db_fall=0.
REQ-027 Scenario 2: N=4; pin 3 pulses high for 3 cycles. Required: gpio_in_db[3] stays 0; db_rise[3] never asserts.
REQ-028 Scenario 3: N=0, then N=1; pin 5 toggles every 4 cycles. Required: output tracks with 3-edge latency, identical for both settings; rise and fall pulses alternate.
REQ-029 Scenario 4: N=100; pin 7 steps to 1. At cnt=50, set N=10. Required: update on the next edge; one db_rise[7].
REQ-030 Scenario 5: N=8; all 32 pins step 0→1 together. Required: gpio_in_db=0xFFFFFFFF at edge 10; db_rise=0xFFFFFFFF for one cycle.
REQ-031 Scenario 6: N=20; pin 2 steps to 1. Assert PRESETn=0 at cnt=10, hold the pad high, release reset. Required: outputs 0 during reset; db_rise[2] exactly 22 edges after release.
